// File: rtl/muldiv32.sv
// muldiv32: iterative RV32M multiply/divide unit.
// Runs a radix-2 shift-add multiply or a restoring divide on operand
// magnitudes, fixes up signs afterwards and drives a one-cycle write-back
// pulse. Division by zero and signed overflow are resolved at accept time.
module muldiv32 #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] ins,
    input  logic [XLEN-1:0] rso1,
    input  logic [XLEN-1:0] rso2,
    input  logic            in_valid,
    output logic            in_ready,
    output logic            wb_en,
    output logic [4:0]      wb_reg,
    output logic [XLEN-1:0] wb_val
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t            r_state, w_next;
    logic [4:0]        r_cnt;
    logic [2:0]        r_f3;
    logic [4:0]        r_rd;
    logic              r_neg;    // product / quotient sign
    logic              r_rneg;   // remainder sign (follows rs1)
    logic [XLEN-1:0]   r_hi;     // product high half / partial remainder
    logic [XLEN-1:0]   r_lo;     // multiplier -> product low / dividend -> quotient
    logic [XLEN-1:0]   r_b;      // multiplicand / divisor magnitude
    logic [4:0]        r_wb_reg;
    logic [XLEN-1:0]   r_wb_val;

    // ---------------- decode at the input ----------------
    logic [2:0]      w_f3;
    logic            w_is_m, w_accept, w_div;
    logic            w_sgn1, w_sgn2, w_neg1, w_neg2;
    logic [XLEN-1:0] w_mag1, w_mag2;
    logic            w_dz, w_ovf, w_special;
    logic [XLEN-1:0] w_spec_val;
    logic            w_unused;

    // rs1/rs2 index fields are resolved by the register file upstream
    assign w_unused  = ^ins[24:15];

    assign w_f3      = ins[14:12];
    assign w_is_m    = (ins[6:0] == 7'b0110011) && (ins[31:25] == 7'b0000001);
    assign w_accept  = in_valid && (r_state == S_IDLE) && w_is_m;
    assign w_div     = w_f3[2];
    // rs1 signed for MUL/MULH/MULHSU/DIV/REM; rs2 signed for MUL/MULH/DIV/REM
    assign w_sgn1    = (w_f3 == 3'd0) || (w_f3 == 3'd1) || (w_f3 == 3'd2) ||
                       (w_f3 == 3'd4) || (w_f3 == 3'd6);
    assign w_sgn2    = (w_f3 == 3'd0) || (w_f3 == 3'd1) ||
                       (w_f3 == 3'd4) || (w_f3 == 3'd6);
    assign w_neg1    = w_sgn1 && rso1[XLEN-1];
    assign w_neg2    = w_sgn2 && rso2[XLEN-1];
    assign w_mag1    = w_neg1 ? (~rso1 + 1'b1) : rso1;
    assign w_mag2    = w_neg2 ? (~rso2 + 1'b1) : rso2;

    assign w_dz      = w_div && (rso2 == '0);
    assign w_ovf     = w_div && !w_f3[0] && (rso1 == {1'b1, {(XLEN-1){1'b0}}}) &&
                       (rso2 == '1);
    assign w_special = w_dz || w_ovf;
    // f3[1] selects remainder; divide-by-zero takes priority over overflow
    assign w_spec_val = w_dz  ? (w_f3[1] ? rso1 : '1) :
                                (w_f3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});

    // ---------------- iteration step ----------------
    logic [XLEN:0]   w_mul_sum;
    logic [XLEN-1:0] w_mul_hi, w_mul_lo;
    logic [XLEN:0]   w_sh;
    logic            w_ge;
    logic [XLEN-1:0] w_sub;

    assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    assign w_mul_hi  = w_mul_sum[XLEN:1];
    assign w_mul_lo  = {w_mul_sum[0], r_lo[XLEN-1:1]};

    // partial remainder < divisor, so shifted value and difference fit
    assign w_sh      = {r_hi, r_lo[XLEN-1]};
    assign w_ge      = w_sh >= {1'b0, r_b};
    assign w_sub     = w_sh[XLEN-1:0] - r_b;

    // ---------------- sign fix-up ----------------
    logic [2*XLEN-1:0] w_prod, w_prod_s;
    logic [XLEN-1:0]   w_quo_s, w_rem_s, w_fix_val;

    assign w_prod    = {r_hi, r_lo};
    assign w_prod_s  = r_neg  ? (~w_prod + 1'b1) : w_prod;
    assign w_quo_s   = r_neg  ? (~r_lo + 1'b1)   : r_lo;
    assign w_rem_s   = r_rneg ? (~r_hi + 1'b1)   : r_hi;
    assign w_fix_val = r_f3[2] ? (r_f3[1] ? w_rem_s : w_quo_s) :
                       (r_f3 == 3'd0) ? w_prod_s[XLEN-1:0] : w_prod_s[2*XLEN-1:XLEN];

    // state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = w_special ? S_DONE : S_CALC;
            S_CALC: if (r_cnt == 5'd31) w_next = S_FIX;
            S_FIX:  w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // operand capture, iteration datapath and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_f3     <= '0;
            r_rd     <= '0;
            r_neg    <= 1'b0;
            r_rneg   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
            r_wb_reg <= '0;
            r_wb_val <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_cnt  <= '0;
                    r_f3   <= w_f3;
                    r_rd   <= ins[11:7];
                    r_neg  <= w_neg1 ^ w_neg2;
                    r_rneg <= w_neg1;
                    r_hi   <= '0;
                    r_b    <= w_div ? w_mag2 : w_mag1;
                    r_lo   <= w_div ? w_mag1 : w_mag2;
                    if (w_special) begin
                        r_wb_reg <= ins[11:7];
                        r_wb_val <= w_spec_val;
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt + 5'd1;
                    if (r_f3[2]) begin
                        r_hi <= w_ge ? w_sub : w_sh[XLEN-1:0];
                        r_lo <= {r_lo[XLEN-2:0], w_ge};
                    end else begin
                        r_hi <= w_mul_hi;
                        r_lo <= w_mul_lo;
                    end
                end
                S_FIX: begin
                    r_wb_reg <= r_rd;
                    r_wb_val <= w_fix_val;
                end
                default: ;
            endcase
        end
    end

    assign in_ready = (r_state == S_IDLE);
    assign wb_en    = (r_state == S_DONE);
    assign wb_reg   = r_wb_reg;
    assign wb_val   = r_wb_val;

endmodule
